mlp_weight_loader: RTL
======================

// Module: mlp_weight_loader
// PURPOSE
//  Load stage driven by the top-level MLP controller. On run_ld, streams N_WORDS words
//  from the host-filled input/weight BRAM into the layer register file. Raises fin_ld on
//  completion; the controller then drops run_ld and starts feed-forward/back-prop.
//  Sits between the GPIO/BRAM host interface and the feed-forward datapath.
// PARAMETERS
//  DATA_W   16  width of one BRAM word / register-file word
//  ADDR_W   10  BRAM and register-file address width
//  N_WORDS  64  words per load (1..2**ADDR_W)
// PORTS
//  clk              in   1       clock
//  reset            in   1       synchronous, active-high reset
//  run_ld           in   1       load request from controller (level)
//  internal_enable  in   1       global stall; 0 = no new BRAM reads issued
//  mem_en           out  1       BRAM read enable
//  mem_addr         out  ADDR_W  BRAM read address
//  mem_rdata        in   DATA_W  BRAM read data; valid 1 cycle after mem_en
//  wr_en            out  1       register-file write strobe
//  wr_addr          out  ADDR_W  register-file write address
//  wr_data          out  DATA_W  register-file write data (= mem_rdata)
//  fin_ld           out  1       load complete (level, registered)
//  busy             out  1       high in READ or DRAIN
//  ld_checksum      out  DATA_W  only with MLP_LD_CHECKSUM_EN
// BEHAVIOUR
//  Reset: state IDLE, read counter 0, valid_q 0, fin_ld 0; hence mem_en/wr_en/busy 0,
//    mem_addr/wr_addr/wr_data 0, ld_checksum 0.
//  FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//  IDLE:  run_ld && internal_enable sampled -> READ, counter <= 0, checksum <= 0.
//  READ:  mem_en = internal_enable (combinational); mem_addr = counter.
//    Counter increments only on edges with mem_en=1.
//    Issuing addr N_WORDS-1 -> DRAIN.
//  Pipeline: valid_q <= mem_en and addr_q <= mem_addr on every edge.
//    wr_en = valid_q; wr_addr = addr_q; wr_data = mem_rdata.
//    internal_enable low stalls issue only; the word already in flight is still written.
//  DRAIN: one cycle for the final write -> DONE, fin_ld <= 1.
//  DONE:  fin_ld held while run_ld = 1. run_ld = 0 -> IDLE, fin_ld <= 0.
//    A new load requires run_ld to fall then rise.
//  Latency, no stalls: fin_ld high N_WORDS+1 edges after the start-sampling edge.
//    Exactly N_WORDS writes, addresses 0..N_WORDS-1 ascending, each exactly once.
//  Abort: run_ld = 0 in READ or DRAIN -> IDLE next edge, fin_ld stays 0, counter cleared.
//    The single in-flight write still completes.
//  run_ld and internal_enable both low in IDLE: stay IDLE.
//  Reset mid-load: immediate return to reset values; no further writes.
//  mem_addr is never >= N_WORDS. N_WORDS = 1 goes READ -> DRAIN after one issue.
// CONFIGURATION
//  MLP_LD_CHECKSUM_EN defined:
//    ld_checksum accumulates wr_data on every wr_en, modulo 2**DATA_W.
//    Cleared on load start; final value valid while fin_ld = 1.
//  MLP_LD_CHECKSUM_EN undefined: port and accumulator absent; all other behaviour identical.
// TESTING
//  T1 N_WORDS=4, BRAM[i]=16'h100+i, run_ld=1 -> writes (0,100),(1,101),(2,102),(3,103);
//     fin_ld rises 5 edges after start.
//  T2 as T1, internal_enable=0 for 3 cycles after the second issue
//     -> same 4 writes, no duplicates; fin_ld delayed by exactly 3 cycles.
//  T3 fin_ld=1, then run_ld=0 -> fin_ld=0 next edge, state IDLE;
//     run_ld=1 again -> full reload from addr 0.
//  T4 run_ld dropped after 2 issues -> at most 2 writes, fin_ld never asserts, IDLE.
//  T5 reset asserted mid-READ -> all outputs 0 next edge; no wr_en afterwards.
//  T6 (MLP_LD_CHECKSUM_EN) BRAM = 16'hFFFF x4 -> ld_checksum = 16'hFFFC at fin_ld.

Source files
------------

// File: rtl/mlp_weight_loader.sv
// Load stage: on run_ld, streams N_WORDS BRAM words into the layer register file and raises fin_ld.
// Optional feature macro: MLP_LD_CHECKSUM_EN adds the ld_checksum output (sum of all written words).
module mlp_weight_loader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int N_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_ld,
    input  logic              internal_enable,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              fin_ld,
    output logic              busy
`ifdef MLP_LD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] ld_checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              fin_d;
    logic              start;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_ld;
        mem_en  = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_ld && internal_enable) begin
                    state_d = READ;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            READ: begin
                // Gating with run_ld keeps an abort from issuing one more read.
                if (!run_ld) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    mem_en = internal_enable;
                    if (internal_enable) begin
                        if (cnt_q == LAST_ADDR) begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!run_ld) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    fin_d   = 1'b1;
                end
            end
            DONE: begin
                if (!run_ld) begin
                    state_d = IDLE;
                    fin_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                fin_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fin_ld  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_ld  <= fin_d;
            valid_q <= mem_en;
            addr_q  <= mem_addr;
        end
    end

    // Counter is cleared on the last issue, so mem_addr never reaches N_WORDS.
    assign mem_addr = cnt_q;
    assign busy     = (state_q == READ) || (state_q == DRAIN);
    assign wr_en    = valid_q;
    assign wr_addr  = addr_q;
    assign wr_data  = valid_q ? mem_rdata : '0;

`ifdef MLP_LD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start) begin
            ld_checksum <= '0;
        end else if (wr_en) begin
            ld_checksum <= ld_checksum + wr_data;
        end
    end
`endif

endmodule
